// File: rtl/cross_product_sequencer.sv
// cross_product_sequencer: operand issue, in-flight tracking and result FIFO
// around the FP21 cross-product datapath (1 sign, 7 exponent, 13 fraction bits).
// Optional macro CROSS_SEQ_DP_REG_EN adds a register stage on dp_* before the
// FIFO write, lengthening the valid delay line and end-to-end latency by one.

`ifndef EXP_MSB
`define EXP_MSB 6
`endif
`ifndef FRAC_MSB
`define FRAC_MSB 12
`endif

module cross_product_sequencer #(
    parameter int LATENCY    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic                a_sign  [2:0],
    input  logic [`EXP_MSB:0]   a_exp   [2:0],
    input  logic [`FRAC_MSB:0]  a_frac  [2:0],
    input  logic                b_sign  [2:0],
    input  logic [`EXP_MSB:0]   b_exp   [2:0],
    input  logic [`FRAC_MSB:0]  b_frac  [2:0],
    output logic                op_sign [11:0],
    output logic [`EXP_MSB:0]   op_exp  [11:0],
    output logic [`FRAC_MSB:0]  op_frac [11:0],
    input  logic                dp_sign [2:0],
    input  logic [`EXP_MSB:0]   dp_exp  [2:0],
    input  logic [`FRAC_MSB:0]  dp_frac [2:0],
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_sign [2:0],
    output logic [`EXP_MSB:0]   res_exp  [2:0],
    output logic [`FRAC_MSB:0]  res_frac [2:0]
);

    localparam int EXP_W  = `EXP_MSB + 1;
    localparam int FRAC_W = `FRAC_MSB + 1;
    localparam int COMP_W = 1 + EXP_W + FRAC_W;
    localparam int WORD_W = 3 * COMP_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

`ifdef CROSS_SEQ_DP_REG_EN
    localparam int DL_LEN = LATENCY + 1;
`else
    localparam int DL_LEN = LATENCY;
`endif

    // Operand routing: odd operands come from b, even from a; operands 2, 6
    // and 10 are the subtracted terms and get their sign flipped. OP_IDX holds
    // the source component (0=x, 1=y, 2=z) per operand, operand 0 in the LSBs.
    localparam logic [11:0] OP_FROM_B = 12'hAAA;
    localparam logic [11:0] OP_NEG    = 12'h444;
    localparam logic [23:0] OP_IDX    = {2'd0, 2'd1, 2'd1, 2'd0,
                                         2'd2, 2'd0, 2'd0, 2'd2,
                                         2'd1, 2'd2, 2'd2, 2'd1};

    logic                w_accept;
    logic                w_pop;
    logic                w_tail;
    logic                w_nextSign [11:0];
    logic [EXP_W-1:0]    w_nextExp  [11:0];
    logic [FRAC_W-1:0]   w_nextFrac [11:0];
    logic [WORD_W-1:0]   w_dpWord;
    logic [WORD_W-1:0]   w_writeWord;
    logic [WORD_W-1:0]   w_headWord;

    logic                r_opSign [11:0];
    logic [EXP_W-1:0]    r_opExp  [11:0];
    logic [FRAC_W-1:0]   r_opFrac [11:0];
    logic [DL_LEN-1:0]   r_validPipe;
    logic [CNT_W-1:0]    r_creditsUsed;
    logic [CNT_W-1:0]    r_fifoCount;
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on registered credit state so it never loops back
    // through the producer's valid or the consumer's ready.
    assign vec_ready = (r_creditsUsed < CNT_W'(FIFO_DEPTH));
    assign res_valid = (r_fifoCount != '0);
    assign w_accept  = vec_valid && vec_ready;
    assign w_pop     = res_valid && res_ready;
    assign w_tail    = r_validPipe[DL_LEN-1];

    // Build the permuted, sign-adjusted operand set from the incoming pair.
    always_comb begin
        w_nextSign = '{default: 1'b0};
        w_nextExp  = '{default: '0};
        w_nextFrac = '{default: '0};
        for (int k = 0; k < 12; k++) begin
            if (OP_FROM_B[k]) begin
                w_nextSign[k] = b_sign[OP_IDX[2*k +: 2]] ^ OP_NEG[k];
                w_nextExp[k]  = b_exp[OP_IDX[2*k +: 2]];
                w_nextFrac[k] = b_frac[OP_IDX[2*k +: 2]];
            end else begin
                w_nextSign[k] = a_sign[OP_IDX[2*k +: 2]] ^ OP_NEG[k];
                w_nextExp[k]  = a_exp[OP_IDX[2*k +: 2]];
                w_nextFrac[k] = a_frac[OP_IDX[2*k +: 2]];
            end
        end
    end

    // Issue register: loads only on accept so the datapath sees stable operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opSign <= '{default: 1'b0};
            r_opExp  <= '{default: '0};
            r_opFrac <= '{default: '0};
        end else if (w_accept) begin
            r_opSign <= w_nextSign;
            r_opExp  <= w_nextExp;
            r_opFrac <= w_nextFrac;
        end
    end

    assign op_sign = r_opSign;
    assign op_exp  = r_opExp;
    assign op_frac = r_opFrac;

    // Latency-matched delay line; its tail marks the cycle a real result is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_validPipe <= '0;
        end else begin
            r_validPipe <= (r_validPipe << 1) | DL_LEN'(w_accept);
        end
    end

    // Flatten the three datapath result components into one FIFO word.
    always_comb begin
        w_dpWord = '0;
        for (int i = 0; i < 3; i++) begin
            w_dpWord[i*COMP_W +: COMP_W] = {dp_sign[i], dp_exp[i], dp_frac[i]};
        end
    end

`ifdef CROSS_SEQ_DP_REG_EN
    logic [WORD_W-1:0] r_dpWord;

    // Capture the datapath result one cycle ahead of its FIFO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dpWord <= '0;
        end else if (r_validPipe[DL_LEN-2]) begin
            r_dpWord <= w_dpWord;
        end
    end

    assign w_writeWord = r_dpWord;
`else
    assign w_writeWord = w_dpWord;
`endif

    // Credits cover everything issued but not yet popped; a tail only moves
    // a credit from in-flight to stored, so it does not touch this count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_creditsUsed <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_creditsUsed <= r_creditsUsed + CNT_W'(1);
                2'b01:   r_creditsUsed <= r_creditsUsed - CNT_W'(1);
                default: r_creditsUsed <= r_creditsUsed;
            endcase
        end
    end

    // FIFO occupancy and wrap-around pointers; write and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifoCount <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
        end else begin
            case ({w_tail, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + CNT_W'(1);
                2'b01:   r_fifoCount <= r_fifoCount - CNT_W'(1);
                default: r_fifoCount <= r_fifoCount;
            endcase
            if (w_tail) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
        end
    end

    // Result storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (w_tail) begin
            r_mem[r_wrPtr] <= w_writeWord;
        end
    end

    assign w_headWord = r_mem[r_rdPtr];

    // First-word fall-through head, forced to zero while the FIFO is empty.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            res_sign[i] = 1'b0;
            res_exp[i]  = '0;
            res_frac[i] = '0;
            if (res_valid) begin
                {res_sign[i], res_exp[i], res_frac[i]} = w_headWord[i*COMP_W +: COMP_W];
            end
        end
    end

endmodule
